// File: rtl/fft_frame_sched_pkg.sv
// fft_sched_pkg: shared types and constants for the FFT frame scheduler.
//   sched_state_e : scheduler FSM states (IDLE, CFG, DATA)
//   CFG_DIR_BIT   : position of the direction bit inside the core config word
//   CFG_FWD/INV   : direction encodings (1 = forward, 0 = inverse)
//   cfg_word()    : builds the 8-bit config word for a given direction
package fft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    DATA = 2'd2
  } sched_state_e;

  localparam int   CFG_DIR_BIT = 0;
  localparam logic CFG_FWD     = 1'b1;
  localparam logic CFG_INV     = 1'b0;

  // Config word: only the direction bit is populated, all other bits zero.
  function automatic logic [7:0] cfg_word(input logic dir);
    logic [7:0] w;
    w              = 8'h00;
    w[CFG_DIR_BIT] = dir;
    return w;
  endfunction

endpackage

// File: rtl/fft_frame_sched_tag_fifo.sv
// tag_fifo: 1-bit wide, DEPTH-deep synchronous FIFO holding the requester ID
// of every frame handed to the FFT core and not yet fully returned.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write a tag (ignored when full)
//   pop             : drop the head tag (ignored when empty)
//   head, head_vld  : current head tag, valid while the FIFO is non-empty
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   push_data,
  input  logic                   pop,
  output logic                   head,
  output logic                   head_vld,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign head_vld  = ~empty;
  assign count     = count_r;

  // Storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 1'b0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: shares one streaming FFT core between two requesters.
// Whole frames are granted round-robin; a config word is sent to the core
// only when the transform direction differs from the one last configured.
// Each forwarded frame's requester ID is queued so results can be attributed.
//   s0_*/s1_*           : requester AXI-S inputs plus per-frame direction
//   cfg_*               : core config channel (registered)
//   c_*                 : core data-in channel (combinational pass-through)
//   res_hs/res_tlast    : observed result handshake from the core
//   res_tid/res_tid_vld : requester of the frame now leaving the core
//   inflight            : frames granted but not fully returned
//   err_len/err_tag     : one-cycle error pulses (registered)
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 1024,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            s0_tdata,
  input  logic                         s0_tvalid,
  output logic                         s0_tready,
  input  logic                         s0_tlast,
  input  logic                         s0_dir,
  input  logic [DATA_W-1:0]            s1_tdata,
  input  logic                         s1_tvalid,
  output logic                         s1_tready,
  input  logic                         s1_tlast,
  input  logic                         s1_dir,
  output logic [7:0]                   cfg_tdata,
  output logic                         cfg_tvalid,
  input  logic                         cfg_tready,
  output logic [DATA_W-1:0]            c_tdata,
  output logic                         c_tvalid,
  input  logic                         c_tready,
  output logic                         c_tlast,
  input  logic                         res_hs,
  input  logic                         res_tlast,
  output logic                         res_tid,
  output logic                         res_tid_vld,
  output logic [$clog2(TAG_DEPTH):0]   inflight,
  output logic                         err_len,
  output logic                         err_tag
);

  localparam int CW = $clog2(FRAME_LEN);

  sched_state_e  state_r;
  logic          gnt_r;
  logic          dir_r;
  logic          cur_dir_r;
  logic          cfg_known_r;
  logic          last_r;
  logic [CW-1:0] cnt_r;
  logic          cfg_tvalid_r;
  logic [7:0]    cfg_tdata_r;
  logic          err_len_r;
  logic          err_tag_r;

  logic [DATA_W-1:0] g_tdata_s;
  logic              g_tvalid_s;
  logic              g_tlast_s;
  logic              in_data_s;
  logic              beat_s;
  logic              at_end_s;
  logic              frame_end_s;
  logic              pick_s;
  logic              pick_dir_s;
  logic              can_grant_s;
  logic              res_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  // Granted-source mux and the DATA-state pass-through to the core.
  always_comb begin
    g_tdata_s  = s0_tdata;
    g_tvalid_s = s0_tvalid;
    g_tlast_s  = s0_tlast;
    if (gnt_r) begin
      g_tdata_s  = s1_tdata;
      g_tvalid_s = s1_tvalid;
      g_tlast_s  = s1_tlast;
    end else begin
      g_tdata_s  = s0_tdata;
      g_tvalid_s = s0_tvalid;
      g_tlast_s  = s0_tlast;
    end
  end

  assign in_data_s   = (state_r == DATA);
  assign at_end_s    = (cnt_r == CW'(FRAME_LEN - 1));
  assign c_tdata     = g_tdata_s;
  assign c_tvalid    = in_data_s & g_tvalid_s;
  assign c_tlast     = in_data_s & (g_tlast_s | at_end_s);
  assign s0_tready   = in_data_s & ~gnt_r & c_tready;
  assign s1_tready   = in_data_s &  gnt_r & c_tready;
  assign beat_s      = c_tvalid & c_tready;
  assign frame_end_s = beat_s & (g_tlast_s | at_end_s);
  assign res_pop_s   = res_hs & res_tlast;
  assign can_grant_s = ~fifo_full_s & (s0_tvalid | s1_tvalid);

  // Round-robin pick: on contention serve the requester not served last.
  always_comb begin
    pick_s = 1'b0;
    if (s0_tvalid && s1_tvalid) begin
      pick_s = ~last_r;
    end else if (s1_tvalid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    pick_dir_s = pick_s ? s1_dir : s0_dir;
  end

  // Scheduler FSM: grant, optional reconfiguration, frame forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      gnt_r        <= 1'b0;
      dir_r        <= 1'b0;
      cur_dir_r    <= 1'b0;
      cfg_known_r  <= 1'b0;
      last_r       <= 1'b1;
      cnt_r        <= {CW{1'b0}};
      cfg_tvalid_r <= 1'b0;
      cfg_tdata_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (can_grant_s) begin
            gnt_r  <= pick_s;
            last_r <= pick_s;
            dir_r  <= pick_dir_s;
            if (!cfg_known_r || (pick_dir_s != cur_dir_r)) begin
              state_r      <= CFG;
              cfg_tvalid_r <= 1'b1;
              cfg_tdata_r  <= cfg_word(pick_dir_s);
            end else begin
              state_r <= DATA;
            end
          end
        end
        CFG: begin
          // Word held stable until the core takes it.
          if (cfg_tready) begin
            cur_dir_r    <= dir_r;
            cfg_known_r  <= 1'b1;
            cfg_tvalid_r <= 1'b0;
            cfg_tdata_r  <= 8'h00;
            state_r      <= DATA;
          end
        end
        DATA: begin
          if (frame_end_s) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else if (beat_s) begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Error pulses: length mismatch on a closing beat, result tlast with no tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_len_r <= 1'b0;
      err_tag_r <= 1'b0;
    end else begin
      err_len_r <= frame_end_s & (g_tlast_s != at_end_s);
      err_tag_r <= res_pop_s & fifo_empty_s;
    end
  end

  assign cfg_tvalid = cfg_tvalid_r;
  assign cfg_tdata  = cfg_tdata_r;
  assign err_len    = err_len_r;
  assign err_tag    = err_tag_r;

  tag_fifo #(
    .DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (frame_end_s),
    .push_data(gnt_r),
    .pop      (res_pop_s),
    .head     (res_tid),
    .head_vld (res_tid_vld),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (inflight)
  );

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed, scoreboard-based bench for fft_frame_sched.
// Source models feed numbered beats; expected frames (source, closing beat,
// length error, config word) and tags are queued as stimulus is issued and
// checked against the core-side outputs every cycle.
module tb_fft_frame_sched;

  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 1024;
  localparam int TAG_DEPTH = 4;
  localparam int IW        = $clog2(TAG_DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] s0_tdata, s1_tdata;
  logic              s0_tvalid, s0_tready, s0_tlast, s0_dir;
  logic              s1_tvalid, s1_tready, s1_tlast, s1_dir;
  logic [7:0]        cfg_tdata;
  logic              cfg_tvalid, cfg_tready;
  logic [DATA_W-1:0] c_tdata;
  logic              c_tvalid, c_tready, c_tlast;
  logic              res_hs, res_tlast, res_tid, res_tid_vld;
  logic [IW-1:0]     inflight;
  logic              err_len, err_tag;

  fft_frame_sched #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s0_tlast(s0_tlast), .s0_dir(s0_dir),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s1_tlast(s1_tlast), .s1_dir(s1_dir),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready), .c_tlast(c_tlast),
    .res_hs(res_hs), .res_tlast(res_tlast), .res_tid(res_tid), .res_tid_vld(res_tid_vld),
    .inflight(inflight), .err_len(err_len), .err_tag(err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int tl; bit dir; } src_frm_t;
  typedef struct { int src; int end_beat; bit err; int cfg; } exp_frm_t;

  src_frm_t src_q0[$];
  src_frm_t src_q1[$];
  exp_frm_t exp_q[$];
  int       tag_q[$];
  int       sbeat0, sbeat1;
  bit       acc0, acc1;
  int       n_chk, n_fail;
  int       mon_beat;
  bit       cfg_seen, err_len_exp, err_tag_exp, rand_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int end_of(input int tl);
    return (tl >= 0 && tl < FRAME_LEN - 1) ? tl : FRAME_LEN - 1;
  endfunction

  task automatic drive();
    s0_tvalid = (src_q0.size() > 0);
    s0_tdata  = {16'd0, 16'(sbeat0)};
    s0_tlast  = (src_q0.size() > 0) && (src_q0[0].tl == sbeat0);
    s0_dir    = (src_q0.size() > 0) ? src_q0[0].dir : 1'b0;
    s1_tvalid = (src_q1.size() > 0);
    s1_tdata  = {16'd1, 16'(sbeat1)};
    s1_tlast  = (src_q1.size() > 0) && (src_q1[0].tl == sbeat1);
    s1_dir    = (src_q1.size() > 0) ? src_q1[0].dir : 1'b0;
    c_tready   = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    cfg_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic push_frame(input int src, input int tl, input bit dir, input int cfg);
    src_frm_t f;
    exp_frm_t e;
    f.tl = tl; f.dir = dir;
    if (src == 0) src_q0.push_back(f); else src_q1.push_back(f);
    e.src = src; e.end_beat = end_of(tl); e.err = (tl != FRAME_LEN - 1); e.cfg = cfg;
    exp_q.push_back(e);
    drive();
  endtask

  // One clock: check at negedge against the model, advance model, redrive.
  task automatic step();
    exp_frm_t e;
    bit push_now, pop_now;
    int push_tag;
    @(negedge clk);
    chk("inflight", inflight, tag_q.size());
    chk("res_tid_vld", res_tid_vld, tag_q.size() > 0);
    if (tag_q.size() > 0) chk("res_tid", res_tid, tag_q[0]);
    chk("err_len", err_len, err_len_exp);
    chk("err_tag", err_tag, err_tag_exp);
    err_len_exp = 1'b0; err_tag_exp = 1'b0;
    push_now = 1'b0; pop_now = 1'b0; push_tag = 0;
    if (cfg_tvalid && cfg_tready) begin
      if (exp_q.size() == 0) chk("unexpected_cfg", cfg_tvalid, 1'b0);
      else begin
        chk("cfg_tdata", cfg_tdata, exp_q[0].cfg);
        cfg_seen = 1'b1;
      end
    end
    if (c_tvalid && c_tready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", c_tvalid, 1'b0);
      else begin
        e = exp_q[0];
        if (mon_beat == 0) chk("cfg_before_frame", cfg_seen, e.cfg >= 0);
        chk("c_tdata", c_tdata, {16'(e.src), 16'(mon_beat)});
        chk("c_tlast", c_tlast, mon_beat == e.end_beat);
        chk("other_tready", (e.src != 0) ? s0_tready : s1_tready, 1'b0);
        if (mon_beat == e.end_beat) begin
          err_len_exp = e.err;
          push_now = 1'b1; push_tag = e.src;
          void'(exp_q.pop_front());
          mon_beat = 0; cfg_seen = 1'b0;
        end else begin
          mon_beat++;
        end
      end
    end
    if (res_hs && res_tlast) begin
      if (tag_q.size() == 0) err_tag_exp = 1'b1; else pop_now = 1'b1;
    end
    if (pop_now) void'(tag_q.pop_front());
    if (push_now) tag_q.push_back(push_tag);
    acc0 = s0_tvalid & s0_tready;
    acc1 = s1_tvalid & s1_tready;
    @(posedge clk);
    #1;
    if (acc0) begin
      if (sbeat0 == end_of(src_q0[0].tl)) begin void'(src_q0.pop_front()); sbeat0 = 0; end
      else sbeat0++;
    end
    if (acc1) begin
      if (sbeat1 == end_of(src_q1[0].tl)) begin void'(src_q1.pop_front()); sbeat1 = 0; end
      else sbeat1++;
    end
    drive();
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() > 0) && (k < budget)) begin
      step();
      k++;
    end
    chk(tag, exp_q.size(), 0);
    step();
  endtask

  task automatic pulse_result();
    res_hs = 1'b1; res_tlast = 1'b1;
    step();
    res_hs = 1'b0; res_tlast = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    src_q0.delete(); src_q1.delete();
    sbeat0 = 0; sbeat1 = 0;
    res_hs = 1'b0; res_tlast = 1'b0;
    drive();
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_cfg_tvalid", cfg_tvalid, 1'b0);
    chk("rst_c_tvalid", c_tvalid, 1'b0);
    chk("rst_c_tlast", c_tlast, 1'b0);
    chk("rst_s0_tready", s0_tready, 1'b0);
    chk("rst_s1_tready", s1_tready, 1'b0);
    chk("rst_res_tid_vld", res_tid_vld, 1'b0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_err_tag", err_tag, 1'b0);
    rst = 1'b0;
    exp_q.delete(); tag_q.delete();
    mon_beat = 0; cfg_seen = 1'b0; err_len_exp = 1'b0; err_tag_exp = 1'b0;
  endtask

  initial begin
    int k;
    n_chk = 0; n_fail = 0; rand_rdy = 1'b0;
    rst = 1'b1; res_hs = 1'b0; res_tlast = 1'b0;
    sbeat0 = 0; sbeat1 = 0;
    drive();
    do_reset(3);

    // Single forward frame from s0: cfg 0x01 then 1024 beats.
    rand_rdy = 1'b1;
    push_frame(0, FRAME_LEN - 1, 1'b1, 1);
    run_until_done("single_frame_done", 4000);
    chk("single_inflight", inflight, 1);
    chk("single_res_tid", res_tid, 1'b0);
    chk("single_res_tid_vld", res_tid_vld, 1'b1);

    // Drain the one tag, then a result tlast on an empty FIFO.
    pulse_result();
    chk("drain_inflight", inflight, 0);
    pulse_result();
    chk("empty_pop_err_tag", err_tag, 1'b1);
    chk("empty_pop_inflight", inflight, 0);

    // Same direction again: no cfg; then a push and pop in the same cycle.
    rand_rdy = 1'b0;
    push_frame(0, 15, 1'b1, -1);
    run_until_done("samedir_done", 200);
    push_frame(1, 15, 1'b1, -1);
    k = 0;
    while (!(s1_tvalid && s1_tready && s1_tlast) && (k < 200)) begin
      step();
      k++;
    end
    chk("reach_last_beat", s1_tlast & s1_tready, 1'b1);
    pulse_result();
    chk("push_pop_inflight", inflight, 1);
    chk("push_pop_res_tid", res_tid, 1'b1);
    step();

    // Contention with alternating directions: grants 0,1,0,1, cfg each time.
    do_reset(1);
    rand_rdy = 1'b1;
    push_frame(0, FRAME_LEN - 1, 1'b1, 1);
    push_frame(1, FRAME_LEN - 1, 1'b0, 0);
    push_frame(0, FRAME_LEN - 1, 1'b1, 1);
    push_frame(1, FRAME_LEN - 1, 1'b0, 0);
    run_until_done("alternate_done", 8000);
    chk("full_inflight", inflight, 4);

    // FIFO full: a waiting request must not be granted.
    push_frame(0, 15, 1'b1, 1);
    repeat (5) step();
    chk("full_s0_tready", s0_tready, 1'b0);
    chk("full_s1_tready", s1_tready, 1'b0);
    chk("full_cfg_tvalid", cfg_tvalid, 1'b0);
    chk("full_inflight_hold", inflight, 4);
    pulse_result();
    chk("after_pop_inflight", inflight, 3);
    k = 0;
    while (!cfg_tvalid && (k < 2)) begin
      step();
      k++;
    end
    chk("regrant_within_2", cfg_tvalid, 1'b1);
    run_until_done("regrant_done", 400);

    // Length errors: early tlast at beat 99, then a frame with no tlast.
    do_reset(1);
    push_frame(1, 99, 1'b0, 0);
    push_frame(1, -1, 1'b0, -1);
    run_until_done("len_err_done", 4000);
    chk("len_err_res_tid", res_tid, 1'b1);
    chk("len_err_inflight", inflight, 2);

    // Reset in the middle of a frame, then cfg must be reissued.
    push_frame(0, FRAME_LEN - 1, 1'b0, -1);
    k = 0;
    while ((sbeat0 < 500) && (k < 2000)) begin
      step();
      k++;
    end
    chk("reach_beat_500", sbeat0, 500);
    do_reset(1);
    push_frame(0, 15, 1'b0, 0);
    run_until_done("post_reset_done", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame-level scheduler that shares one streaming FFT core between two requesters. It grants whole frames round-robin and issues a config word to the core only when the transform direction changes. It forwards the granted frame to the core's data input and tags each in-flight frame so results leaving the core can be attributed to their requester. It sits between the two producer streams and the FFT core wrapper's config and data slave channels.

## Interface
- DATA_W, 32, sample width (packed re/im) on the input streams and core data channel
- FRAME_LEN, 1024, beats per frame; must be a power of 2, ≥ 8
- TAG_DEPTH, 4, maximum frames in flight inside the core; power of 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sN_tdata  in  DATA_W  requester N sample (N = 0, 1)
- sN_tvalid  in  1  requester N valid
- sN_tready  out  1  requester N ready
- sN_tlast  in  1  requester N end of frame
- sN_dir  in  1  requester N direction (1 = forward, 0 = inverse); sampled at grant
- cfg_tdata  out  8  core config word: bit0 = direction, bits 7:1 = 0
- cfg_tvalid  out  1  core config valid
- cfg_tready  in  1  core config ready
- c_tdata  out  DATA_W  core data-in sample
- c_tvalid  out  1  core data-in valid
- c_tready  in  1  core data-in ready
- c_tlast  out  1  core data-in end of frame
- res_hs  in  1  core result beat accepted (m_tvalid & m_tready, observed)
- res_tlast  in  1  core result tlast
- res_tid  out  1  requester ID of the frame currently leaving the core
- res_tid_vld  out  1  res_tid meaningful (tag FIFO not empty)
- inflight  out  log2(TAG_DEPTH)+1  frames granted but not yet fully output
- err_len  out  1  one-cycle pulse on a frame-length mismatch
- err_tag  out  1  one-cycle pulse on a result tlast with an empty tag FIFO

## Operation
- FSM states: IDLE, CFG, DATA.
- IDLE: if inflight < TAG_DEPTH and any sN_tvalid, grant one requester. On contention, grant the requester not served last; after reset, requester 0 has priority. Latch gnt and dir = sN_dir.
  - If cfg_known = 0 or dir ≠ cur_dir: go to CFG.
  - Otherwise: go to DATA.
- CFG: cfg_tvalid = 1, cfg_tdata = {7'b0, dir}. On cfg_tready: cur_dir ← dir, cfg_known ← 1, go to DATA.
- DATA: combinational pass-through of the granted source.
  - c_tdata = sG_tdata, c_tvalid = sG_tvalid, sG_tready = c_tready.
  - The non-granted sN_tready = 0.
  - A beat counter increments on each c_tvalid & c_tready.
- Frame end is the first accepted beat where sG_tlast = 1 or count = FRAME_LEN-1.
  - c_tlast = 1 on that beat.
  - Push gnt into the tag FIFO, clear the counter, go to IDLE.
  - err_len pulses if sG_tlast and (count = FRAME_LEN-1) disagree. The frame is still closed, with the truncation/forced-end semantics above.
- Result side: on res_hs & res_tlast, pop the tag FIFO.
  - Pop when empty: err_tag pulses, no state change.
  - Simultaneous push and pop: inflight unchanged, both take effect.
- inflight = FIFO occupancy. Granting is blocked while the FIFO is full. Frames in DATA always have a free slot, so push never overflows.
- Reset (any state, including mid-frame):
  - FSM → IDLE, counter = 0, FIFO emptied, cfg_known = 0, cur_dir = 0, round-robin pointer = requester 1 (last served), so requester 0 wins first contention.
  - All outputs 0: cfg_tvalid, c_tvalid, c_tlast, sN_tready, res_tid_vld, inflight, err_len, err_tag.
  - A partially forwarded frame is abandoned; the core is reset separately.

## Timing
- Grant decision: 1 cycle in IDLE (IDLE → CFG/DATA registered).
- CFG lasts ≥ 1 cycle; cfg_tvalid holds with stable cfg_tdata until cfg_tready.
- DATA path: zero-latency combinational; the tready path is combinational from c_tready.
- Frame-to-frame bubble: 1 cycle (IDLE) with no reconfiguration, ≥ 2 cycles with reconfiguration.
- err_len and err_tag are registered, asserted the cycle after the offending beat.
- res_tid is registered FIFO-head output; it updates the cycle after a pop.

## Structure
- Package fft_sched_pkg holds:
  - the state enum (IDLE, CFG, DATA);
  - CFG_DIR_BIT = 0, CFG_FWD = 1'b1, CFG_INV = 1'b0.
- Sub-module tag_fifo: 1-bit wide, TAG_DEPTH deep, synchronous, with count output. It also serves inflight.

## Test plan
- Reset then s0 sends a 1024-beat frame, dir = 1 → one cfg beat with 0x01, then 1024 beats with c_tlast on beat 1023; inflight = 1; res_tid = 0 at output.
- s0 and s1 valid continuously, dirs 1/0 → grants alternate 0,1,0,1; cfg 0x01, 0x00, 0x01, 0x00 before each frame. Same dirs → cfg issued only before the first frame.
- Four frames granted, no res_hs → inflight = 4, no fifth grant, both sN_tready = 0. One res_hs & res_tlast → inflight = 3, next grant within 2 cycles.
- s1 asserts tlast at beat 99 → c_tlast on beat 99, err_len pulse, tag 1 pushed. Next frame with no tlast → c_tlast forced on beat 1023, err_len pulse.
- res_hs & res_tlast with empty FIFO → err_tag pulse, inflight stays 0. Grant push and result pop on the same cycle → inflight unchanged.
- rst asserted mid-DATA at beat 500 → next cycle all outputs 0, FSM in IDLE. The next grant reissues cfg even if dir is unchanged.
